// File: rtl/vga_pixel_fetch_if.sv
// Frame-buffer read port between the pixel fetch stage and the memory.
// Avalon-MM style pipelined read with variable latency.
//   mem_address       : word-aligned byte address (bits [1:0] always 0)
//   mem_read          : read request, held until accepted
//   mem_waitrequest   : slave stall; a request is accepted when mem_read && !mem_waitrequest
//   mem_readdata      : returned 32-bit word
//   mem_readdatavalid : mem_readdata is valid this cycle
// master = fetch stage, slave = memory.
interface vga_pixel_fetch_if #(
  parameter int ADDR_W = 24
) ();
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_waitrequest;
  logic [31:0]       mem_readdata;
  logic              mem_readdatavalid;

  modport master (
    output mem_address,
    output mem_read,
    input  mem_waitrequest,
    input  mem_readdata,
    input  mem_readdatavalid
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    output mem_waitrequest,
    output mem_readdata,
    output mem_readdatavalid
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage in front of the VGA timing/pattern generator.
// Turns the generator's per-pixel byte address into an 8-bit grey level,
// caching one 32-bit frame-buffer word (4 pixels) and fetching a new word
// on a miss. Pixels that cannot be served in time are counted as underruns.
// Ports:
//   clk            : pixel clock (shared with the generator)
//   reset_n        : asynchronous active-low reset
//   pixel_addr     : byte address of the current pixel
//   color          : grey level for the current pixel, 1-cycle latency
//   mem            : frame-buffer read port (master side)
//   underrun_count : saturating count of miss cycles
//   busy           : a read is outstanding
module vga_pixel_fetch #(
  parameter int                ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] BLANK_ADDR  = '0,
  parameter logic [7:0]        BLANK_COLOR = 8'h00
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pixel_addr,
  output logic [7:0]        color,
  vga_pixel_fetch_if.master mem,
  output logic [15:0]       underrun_count,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t state, state_next;

  logic [ADDR_W-3:0] pix_word;
  logic [1:0]        pix_lane;
  logic [ADDR_W-3:0] req_word;
  logic [ADDR_W-3:0] tag;
  logic [31:0]       data;
  logic              tag_valid;

  logic is_blank, is_hit, is_bypass, is_miss;
  logic issue, accept, fill;

  assign pix_word = pixel_addr[ADDR_W-1:2];
  assign pix_lane = pixel_addr[1:0];

  // Blank wins over everything so the blank address is never fetched.
  // A returning word that matches the current pixel is used directly
  // (bypass) so the pixel is not lost while the cache is being written.
  assign is_blank  = (pixel_addr == BLANK_ADDR);
  assign is_hit    = tag_valid && (tag == pix_word);
  assign is_bypass = (state == RESP) && mem.mem_readdatavalid && (req_word == pix_word);
  assign is_miss   = !is_blank && !is_hit && !is_bypass;

  function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] l);
    return w[8*l +: 8];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // One read in flight at most: a new request can only start from IDLE,
  // so a miss seen during REQ/RESP waits until the current fill lands.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    accept     = 1'b0;
    fill       = 1'b0;
    case (state)
      IDLE: begin
        if (is_miss) begin
          issue      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (!mem.mem_waitrequest) begin
          accept     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (mem.mem_readdatavalid) begin
          fill       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request registers, cache fill and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_word        <= '0;
      mem.mem_address <= '0;
      mem.mem_read    <= 1'b0;
      tag             <= '0;
      data            <= '0;
      tag_valid       <= 1'b0;
      busy            <= 1'b0;
    end else begin
      if (issue) begin
        req_word        <= pix_word;
        mem.mem_address <= {pix_word, 2'b00};
        mem.mem_read    <= 1'b1;
      end
      if (accept) mem.mem_read <= 1'b0;
      if (fill) begin
        tag       <= req_word;
        data      <= mem.mem_readdata;
        tag_valid <= 1'b1;
      end
      busy <= (state_next != IDLE);
    end
  end

  // Pixel output and underrun counter; color holds on a miss.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      color          <= BLANK_COLOR;
      underrun_count <= '0;
    end else begin
      if (is_blank)       color <= BLANK_COLOR;
      else if (is_hit)    color <= lane_sel(data, pix_lane);
      else if (is_bypass) color <= lane_sel(mem.mem_readdata, pix_lane);
      if (is_miss && (underrun_count != 16'hFFFF))
        underrun_count <= underrun_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed self-checking bench for vga_pixel_fetch. The memory side is
// scripted cycle by cycle; expected values are worked out by hand.
module tb_vga_pixel_fetch;

  logic        clk;
  logic        reset_n;
  logic [23:0] pixel_addr;
  logic [7:0]  color;
  logic [15:0] underrun_count;
  logic        busy;

  int checks;
  int passes;
  int accepts;

  vga_pixel_fetch_if #(.ADDR_W(24)) mem_bus ();

  vga_pixel_fetch #(
    .ADDR_W     (24),
    .BLANK_ADDR (24'd0),
    .BLANK_COLOR(8'h00)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pixel_addr    (pixel_addr),
    .color         (color),
    .mem           (mem_bus),
    .underrun_count(underrun_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count request handshakes as the edge approaches, then step past it.
  task automatic tick();
    if (mem_bus.mem_read && !mem_bus.mem_waitrequest) accepts++;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [23:0] addr, input logic wr,
                               input logic valid, input logic [31:0] rdata);
    pixel_addr                = addr;
    mem_bus.mem_waitrequest   = wr;
    mem_bus.mem_readdatavalid = valid;
    mem_bus.mem_readdata      = rdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  initial begin
    logic any_read;
    checks  = 0;
    passes  = 0;
    accepts = 0;
    reset_n = 1'b0;
    applyStimulus(24'd0, 1'b0, 1'b0, 32'h0);

    // Reset state
    #1;
    checkOutput("reset_color", color, 8'h00);
    checkOutput("reset_read", mem_bus.mem_read, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_underrun", underrun_count, 16'd0);
    checkOutput("reset_address", mem_bus.mem_address, 24'd0);
    tick();
    reset_n = 1'b1;

    // Blank pixels: no request, no underrun
    any_read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_bus.mem_read) any_read = 1'b1;
    end
    checkOutput("blank_no_read", any_read, 1'b0);
    checkOutput("blank_color", color, 8'h00);
    checkOutput("blank_underrun", underrun_count, 16'd0);

    // Miss at 376, accepted immediately, data valid 3 cycles after accept
    accepts = 0;
    applyStimulus(24'd376, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("miss376_read", mem_bus.mem_read, 1'b1);
    checkOutput("miss376_address", mem_bus.mem_address, 24'd376);
    checkOutput("miss376_busy", busy, 1'b1);
    tick();
    checkOutput("miss376_read_pulse", mem_bus.mem_read, 1'b0);
    tick();
    tick();
    applyStimulus(24'd376, 1'b0, 1'b1, 32'h44332211);
    tick();
    checkOutput("bypass376_color", color, 8'h11);
    checkOutput("bypass376_underrun", underrun_count, 16'd4);
    checkOutput("bypass376_busy", busy, 1'b0);

    // Hits on the remaining lanes of the cached word
    applyStimulus(24'd377, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("hit377_color", color, 8'h22);
    applyStimulus(24'd378, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("hit378_color", color, 8'h33);
    applyStimulus(24'd379, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("hit379_color", color, 8'h44);
    checkOutput("hit_no_read", mem_bus.mem_read, 1'b0);
    checkOutput("hit_accepts", accepts, 1);
    checkOutput("hit_underrun", underrun_count, 16'd4);

    // Miss at 676 with waitrequest held for 5 cycles
    accepts = 0;
    applyStimulus(24'd676, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("miss676_read", mem_bus.mem_read, 1'b1);
    checkOutput("miss676_address", mem_bus.mem_address, 24'd676);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_read", mem_bus.mem_read, 1'b1);
      checkOutput("stall_address", mem_bus.mem_address, 24'd676);
    end
    applyStimulus(24'd676, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("stall_read_drop", mem_bus.mem_read, 1'b0);
    checkOutput("stall_accepts", accepts, 1);

    // Address moves to 976 while the 676 fill is outstanding
    applyStimulus(24'd976, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("resp_busy", busy, 1'b1);
    applyStimulus(24'd976, 1'b0, 1'b1, 32'hDDCCBBAA);
    tick();
    checkOutput("fill676_idle_busy", busy, 1'b0);
    checkOutput("fill676_color_hold", color, 8'h44);
    checkOutput("fill676_no_read", mem_bus.mem_read, 1'b0);
    applyStimulus(24'd976, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("miss976_read", mem_bus.mem_read, 1'b1);
    checkOutput("miss976_address", mem_bus.mem_address, 24'd976);
    checkOutput("miss976_busy", busy, 1'b1);
    // Blank while the request is accepted: blank color, no underrun
    applyStimulus(24'd0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("blank_in_req_color", color, 8'h00);
    checkOutput("blank_in_req_busy", busy, 1'b1);
    applyStimulus(24'd976, 1'b0, 1'b1, 32'h87654321);
    tick();
    checkOutput("bypass976_color", color, 8'h21);
    checkOutput("bypass976_underrun", underrun_count, 16'd14);
    applyStimulus(24'd979, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("hit979_color", color, 8'h87);
    checkOutput("hit979_no_read", mem_bus.mem_read, 1'b0);

    // Async reset in the middle of RESP, then a stray readdatavalid
    applyStimulus(24'd2000, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", busy, 1'b0);
    checkOutput("async_rst_color", color, 8'h00);
    checkOutput("async_rst_underrun", underrun_count, 16'd0);
    checkOutput("async_rst_read", mem_bus.mem_read, 1'b0);
    tick();
    reset_n = 1'b1;
    applyStimulus(24'd0, 1'b0, 1'b1, 32'hAABBCCDD);
    tick();
    checkOutput("stray_valid_color", color, 8'h00);
    checkOutput("stray_valid_busy", busy, 1'b0);
    applyStimulus(24'd2000, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("post_rst_miss_read", mem_bus.mem_read, 1'b1);
    checkOutput("post_rst_miss_color", color, 8'h00);
    checkOutput("post_rst_underrun", underrun_count, 16'd1);

    // Underrun saturation: a stalled miss for 70000 cycles
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    applyStimulus(24'd2000, 1'b1, 1'b0, 32'h0);
    repeat (65534) tick();
    checkOutput("underrun_near_sat", underrun_count, 16'hFFFE);
    repeat (70000 - 65534) tick();
    checkOutput("underrun_saturated", underrun_count, 16'hFFFF);
    checkOutput("sat_read_held", mem_bus.mem_read, 1'b1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Upstream stage of the VGA timing/pattern generator.
- Takes the generator's per-pixel byte address and returns the 8-bit grey level on its `color` input.
- Reads 32-bit words from the frame-buffer memory port (Avalon-MM style, variable latency, pipelined read) and caches one word (4 pixels).
- Counts pixels that could not be served in time (underruns).

Parameters:
- ADDR_W, 24, width of the pixel byte address (matches the generator's address output).
- BLANK_ADDR, 0, address value the generator drives outside the image window; never fetched.
- BLANK_COLOR, 8'h00, color driven for BLANK_ADDR.

Ports:
- clk  in  1  pixel clock, same clock as the generator.
- reset_n  in  1  asynchronous active-low reset.
- pixel_addr  in  ADDR_W  byte address of the current pixel, from the generator.
- color  out  8  pixel grey level, to the generator's `color` input.
- mem_address  out  ADDR_W  word-aligned byte address; bits [1:0] are always 0.
- mem_read  out  1  read request.
- mem_waitrequest  in  1  slave stall; the request is accepted on a cycle with mem_read=1 and mem_waitrequest=0.
- mem_readdata  in  32  returned word.
- mem_readdatavalid  in  1  mem_readdata is valid this cycle.
- underrun_count  out  16  saturating count of miss cycles.
- busy  out  1  high while a read is outstanding (state != IDLE).

Behaviour:
- Reset (async, active-low): all outputs 0; color=BLANK_COLOR; tag_valid=0; state=IDLE. Reset asserted mid-transaction abandons the read. A mem_readdatavalid arriving in IDLE is ignored.
- Definitions:
  - word(a) = a[ADDR_W-1:2].
  - lane = a[1:0]; lane 0 = readdata[7:0], lane 3 = readdata[31:24].
  - Cache = {tag_valid, tag, data[31:0]}.
- Hit: tag_valid && tag==word(pixel_addr). color <= selected lane of data; 1-cycle latency.
- Blank: pixel_addr==BLANK_ADDR. color <= BLANK_COLOR next cycle; no request issued; not counted as an underrun.
- Miss: neither hit nor blank. color holds its previous value; underrun_count increments by 1 per cycle, saturating at 16'hFFFF.
- FSM:
  - IDLE: on a miss, latch req_word=word(pixel_addr), drive mem_address={req_word,2'b00}, mem_read=1, go to REQ.
  - REQ: hold mem_read and mem_address stable while mem_waitrequest=1. When mem_waitrequest=0, mem_read drops next cycle; go to RESP.
  - RESP: on mem_readdatavalid, load the cache with tag=req_word, data=mem_readdata, tag_valid=1. Go to IDLE.
  - IDLE after a fill: if pixel_addr still misses, a new request is issued on the following cycle (one cycle in IDLE minimum).
- Only one read is outstanding at any time. Cache contents and tag are never modified during REQ.
- Simultaneous return and use: in the cycle mem_readdatavalid=1, if req_word==word(pixel_addr) the cycle counts as a hit. color <= lane of mem_readdata (bypass), with no underrun increment.
- Address change during REQ/RESP: the outstanding request is not cancelled. The fill always completes with req_word, and the next miss is serviced from IDLE afterwards.
- Blank during REQ/RESP: color <= BLANK_COLOR; the fill still completes.
- mem_address, mem_read and busy are registered outputs.

Test Plan:
- Reset, then pixel_addr=0 for 10 cycles -> color=8'h00, mem_read never asserted, underrun_count=0.
- pixel_addr=376, mem_waitrequest=0, readdata=32'h44332211 valid 3 cycles after accept:
  - mem_address=376 with a 1-cycle mem_read pulse;
  - color=8'h11 one cycle after the valid (bypass);
  - underrun_count=4.
- After that fill, step pixel_addr 377, 378, 379 -> color 8'h22, 8'h33, 8'h44 at 1-cycle latency, no new mem_read.
- mem_waitrequest held high 5 cycles on a miss at 676 -> mem_read and mem_address=676 stable all 5 cycles; exactly one request accepted.
- Change pixel_addr 676 -> 976 while in RESP -> fill for word(676) completes first; then a request for 976 issues one cycle after the valid; busy high throughout both reads, except the one IDLE cycle.
- Async reset_n low mid-RESP, then a stray mem_readdatavalid -> cache stays invalid, color=8'h00, FSM in IDLE. Underrun saturation: force 70000 miss cycles -> underrun_count=16'hFFFF.
